// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, handshakes with the instruction ROM and feeds the IF-to-ID register.
// Optional macro IF_ALIGN_CHECK_EN adds fetch_misalign_o and blocks fetches from a misaligned PC.
module if_fetch_unit #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    INST_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    PC_STEP      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_current_stage,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] exc_pc,
    input  logic                  branch_flag,
    input  logic [ADDR_WIDTH-1:0] branch_addr,
    output logic                  rom_en,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic                  rom_ready,
    input  logic [INST_WIDTH-1:0] rom_data,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [INST_WIDTH-1:0] inst_o,
`ifdef IF_ALIGN_CHECK_EN
    output logic                  fetch_misalign_o,
`endif
    output logic                  stall_req_o
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] pc, pc_nxt;
    logic [ADDR_WIDTH-1:0] buf_addr, buf_addr_nxt;
    logic [INST_WIDTH-1:0] buf_inst, buf_inst_nxt;
    logic                  misalign;

    assign rom_addr = pc;

`ifdef IF_ALIGN_CHECK_EN
    assign misalign         = (pc[1:0] != 2'b00);
    assign fetch_misalign_o = (state == REQ) && misalign;
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= RESET_VECTOR;
            buf_addr <= RESET_VECTOR;
            buf_inst <= '0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            buf_addr <= buf_addr_nxt;
            buf_inst <= buf_inst_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        buf_addr_nxt = buf_addr;
        buf_inst_nxt = buf_inst;
        rom_en       = 1'b0;
        addr_o       = pc;
        inst_o       = '0;
        stall_req_o  = 1'b0;

        case (state)
            IDLE: begin
                stall_req_o = 1'b1;
                state_nxt   = REQ;
            end
            REQ: begin
                // A misaligned PC parks here until a redirect arrives.
                if (!misalign) begin
                    rom_en = 1'b1;
                    if (!rom_ready) begin
                        stall_req_o = 1'b1;
                    end else begin
                        inst_o = rom_data;
                        if (stall_current_stage) begin
                            state_nxt    = HOLD;
                            buf_addr_nxt = pc;
                            buf_inst_nxt = rom_data;
                        end else begin
                            pc_nxt = pc + STEP;
                        end
                    end
                end
            end
            HOLD: begin
                // Buffered pair stays visible through the release cycle so ID latches it once.
                addr_o = buf_addr;
                inst_o = buf_inst;
                if (!stall_current_stage) begin
                    pc_nxt    = pc + STEP;
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (flush || branch_flag) begin
            inst_o      = '0;
            stall_req_o = 1'b0;
            state_nxt   = REQ;
            pc_nxt      = flush ? exc_pc : branch_addr;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then randomized traffic against a cycle-level reference model.
module tb_if_fetch_unit;

    localparam logic [31:0] ROM_KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_current_stage = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] exc_pc = '0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        rom_en;
    logic [31:0] rom_addr;
    logic        rom_ready = 1'b0;
    logic [31:0] rom_data;
    logic [31:0] addr_o;
    logic [31:0] inst_o;
    logic        stall_req_o;
`ifdef IF_ALIGN_CHECK_EN
    logic        fetch_misalign_o;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: PC, whether the post-reset idle cycle is done, and a held pair.
    logic [31:0] m_pc;
    bit          m_started;
    bit          m_holding;
    logic [31:0] m_hold_addr;
    logic [31:0] m_hold_inst;

    always #5 clk = ~clk;

    assign rom_data = rom_addr ^ ROM_KEY;

    if_fetch_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall_current_stage (stall_current_stage),
        .flush               (flush),
        .exc_pc              (exc_pc),
        .branch_flag         (branch_flag),
        .branch_addr         (branch_addr),
        .rom_en              (rom_en),
        .rom_addr            (rom_addr),
        .rom_ready           (rom_ready),
        .rom_data            (rom_data),
        .addr_o              (addr_o),
        .inst_o              (inst_o),
`ifdef IF_ALIGN_CHECK_EN
        .fetch_misalign_o    (fetch_misalign_o),
`endif
        .stall_req_o         (stall_req_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_pc        = 32'h0;
        m_started   = 1'b0;
        m_holding   = 1'b0;
        m_hold_addr = 32'h0;
        m_hold_inst = 32'h0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_rom_en", 32'(rom_en), 32'd0);
        chk("rst_addr",   addr_o, 32'h0);
        chk("rst_inst",   inst_o, 32'h0);
        chk("rst_sreq",   32'(stall_req_o), 32'd1);
`ifdef IF_ALIGN_CHECK_EN
        chk("rst_misal",  32'(fetch_misalign_o), 32'd0);
`endif
    endtask

    // Called 1ns after a rising edge: drive inputs, check settled outputs, advance the model.
    task automatic cycle(input bit rdy, input bit stl, input bit br, input logic [31:0] ba,
                         input bit fl, input logic [31:0] ea);
        bit          redirect, mis;
        logic        e_en, e_sreq;
        logic [31:0] e_addr, e_inst;
        rom_ready = rdy; stall_current_stage = stl;
        branch_flag = br; branch_addr = ba;
        flush = fl; exc_pc = ea;
        #3;
        redirect = fl || br;
        mis = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
        mis = m_started && !m_holding && (m_pc[1:0] != 2'b00);
`endif
        e_addr = m_pc; e_inst = 32'h0; e_en = 1'b0; e_sreq = 1'b0;
        if (!m_started) begin
            e_sreq = 1'b1;
        end else if (m_holding) begin
            e_addr = m_hold_addr; e_inst = m_hold_inst;
        end else if (!mis) begin
            e_en = 1'b1;
            if (rdy) e_inst = m_pc ^ ROM_KEY;
            else     e_sreq = 1'b1;
        end
        if (redirect) begin
            e_inst = 32'h0; e_sreq = 1'b0;
        end
        chk("rom_en",   32'(rom_en), 32'(e_en));
        chk("rom_addr", rom_addr, m_pc);
        chk("addr_o",   addr_o, e_addr);
        chk("inst_o",   inst_o, e_inst);
        chk("stall_req", 32'(stall_req_o), 32'(e_sreq));
`ifdef IF_ALIGN_CHECK_EN
        chk("misalign", 32'(fetch_misalign_o), 32'(mis));
`endif
        if (fl) begin
            m_pc = ea; m_started = 1'b1; m_holding = 1'b0;
        end else if (br) begin
            m_pc = ba; m_started = 1'b1; m_holding = 1'b0;
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (m_holding) begin
            if (!stl) begin
                m_pc = m_pc + 32'd4; m_holding = 1'b0;
            end
        end else if (!mis && rdy) begin
            if (stl) begin
                m_holding = 1'b1; m_hold_addr = m_pc; m_hold_inst = m_pc ^ ROM_KEY;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b1;

        // Zero-wait ROM after the idle cycle, then 3 wait states at 0x8.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("pc_after_wait", rom_addr, 32'hC);
        cycle(1, 0, 0, 0, 0, 0);

        // Stall at 0x10 for two cycles, release, then continue at 0x14.
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("pc_after_hold", rom_addr, 32'h14);
        cycle(1, 0, 0, 0, 0, 0);

        // Flush and branch together while holding: flush wins.
        cycle(1, 1, 0, 0, 0, 0);
        cycle(0, 1, 1, 32'h100, 1, 32'h80);
        chk("flush_wins", rom_addr, 32'h80);
        cycle(1, 0, 0, 0, 0, 0);

        // Wrap of the PC past the top of the address space.
        cycle(1, 0, 1, 32'hFFFF_FFFC, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("pc_wrap", rom_addr, 32'h0);
        cycle(1, 0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a wait state.
        cycle(0, 0, 0, 0, 0, 0);
        rom_ready = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b1;
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);

`ifdef IF_ALIGN_CHECK_EN
        cycle(1, 0, 1, 32'h102, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 32'h80);
        cycle(1, 0, 0, 0, 0, 0);
`endif

        // Randomized traffic with aligned redirect targets.
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(99) < 70, $urandom_range(99) < 25,
                  $urandom_range(99) < 6, {$urandom_range(32'h3FFF_FFFF), 2'b00},
                  $urandom_range(99) < 3, {$urandom_range(32'h3FFF_FFFF), 2'b00});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage front end; the producer side of the IF-to-ID pipeline register.
- Owns the PC and runs a request/ready handshake with the instruction ROM.
- Presents the fetched address/instruction pair to the IF-to-ID register; honours stall, branch redirect and exception flush.
- Raises a stall request to the stall controller while the ROM is not ready.

Parameters:
- ADDR_WIDTH, 32, PC/ROM address width (equals ADDR_BUS_WIDTH).
- INST_WIDTH, 32, instruction width (equals INST_BUS_WIDTH).
- RESET_VECTOR, 32'h0000_0000, PC value after reset.
- PC_STEP, 4, PC increment per delivered instruction.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- stall_current_stage  in  1  from stall controller; IF must hold.
- flush  in  1  exception flush; highest priority.
- exc_pc  in  ADDR_WIDTH  exception handler address.
- branch_flag  in  1  taken branch/jump from ID.
- branch_addr  in  ADDR_WIDTH  branch target.
- rom_en  out  1  ROM request.
- rom_addr  out  ADDR_WIDTH  ROM address (= pc).
- rom_ready  in  1  rom_data valid for the current rom_addr this cycle.
- rom_data  in  INST_WIDTH  instruction from ROM.
- addr_o  out  ADDR_WIDTH  to IF-to-ID register addr_i.
- inst_o  out  INST_WIDTH  to IF-to-ID register inst_i.
- stall_req_o  out  1  to stall controller; fetch not ready.

Behaviour:
- Reset (rst low, asynchronous):
  - pc = RESET_VECTOR, state = IDLE, buffer = 0.
  - Outputs: rom_en = 0, addr_o = RESET_VECTOR, inst_o = 0, stall_req_o = 1.
  - Reset asserted mid-operation aborts any fetch immediately.
- State IDLE: one cycle after reset release, then REQ unconditionally. Outputs as at reset.
- State REQ:
  - rom_en = 1, rom_addr = pc.
  - !rom_ready: stall_req_o = 1, inst_o = 0 (NOP bubble), addr_o = pc; stay in REQ.
  - rom_ready && !stall_current_stage: inst_o = rom_data, addr_o = pc, both combinational in the same cycle; stall_req_o = 0; pc <= pc + PC_STEP; stay in REQ. A zero-wait ROM gives 1 instruction per cycle.
  - rom_ready && stall_current_stage: buffer <= rom_data, buf_addr <= pc; go to HOLD; pc unchanged.
- State HOLD:
  - rom_en = 0, stall_req_o = 0, addr_o = buf_addr, inst_o = buffer.
  - When stall_current_stage deasserts: pc <= pc + PC_STEP, go to REQ.
  - Output in the release cycle is the buffered pair, so the IF-to-ID register captures it exactly once.
- Redirect priority: flush > branch_flag > stall > advance.
  - flush: pc <= exc_pc, state <= REQ, buffer discarded. Applies regardless of stall or ROM state.
  - branch_flag (no flush): pc <= branch_addr, state <= REQ, buffer discarded, ROM data in this cycle ignored. Applies regardless of stall. A branch held high across stalled cycles is idempotent.
  - In a redirect cycle: inst_o = 0, stall_req_o = 0.
- ROM interface:
  - Address-combinational with wait states; no outstanding-request tracking.
  - Changing rom_addr abandons the prior request.
  - rom_ready is ignored when rom_en = 0.
- Arithmetic: pc + PC_STEP wraps modulo 2^ADDR_WIDTH (32'hFFFF_FFFC -> 32'h0).
- stall_req_o and stall_current_stage may both be high; stall_req_o never depends combinationally on stall_current_stage (no loop).

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Defined:
  - Adds output port fetch_misalign_o (1 bit, reset 0).
  - If pc[1:0] != 0 in REQ: rom_en = 0, inst_o = 0, stall_req_o = 0, fetch_misalign_o = 1; state stays REQ until flush or branch redirects.
  - All other behaviour is unchanged.
- Undefined: no port; low PC bits are forwarded to the ROM unchecked.

Test Plan:
- Release reset, ROM always ready with data = addr ^ 32'hA5A5_0000 -> IDLE for 1 cycle, then pairs (0x0,0xA5A5_0000), (0x4,0xA5A5_0004), ... one per cycle; stall_req_o low after IDLE.
- ROM ready delayed 3 cycles on pc 0x8 -> stall_req_o high 3 cycles with inst_o = 0; 4th cycle delivers 0x8; pc becomes 0xC.
- rom_ready with stall_current_stage high for 2 cycles at pc 0x10 -> HOLD with buffered pair (0x10,data) stable, rom_en = 0; on release the pair appears once, then pc = 0x14.
- branch_flag (target 0x100) and flush (exc_pc 0x80) in the same cycle, during HOLD -> pc = 0x80, buffer dropped, next delivered addr 0x80.
- pc preset near 32'hFFFF_FFFC via branch, ROM ready -> next addr 0x0 (wrap); rst pulsed low mid-wait -> immediate return to RESET_VECTOR, rom_en = 0.
- With IF_ALIGN_CHECK_EN, branch to 0x102 -> fetch_misalign_o = 1, rom_en = 0; subsequent flush to 0x80 clears it and resumes fetch.
